// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
//
// Purpose:
//   Down-counting loop/index sequencer. A load captures a non-zero start value
//   N; each count_enable in RUN steps the count down towards 1, where
//   term_flag marks the terminal count. The next enable at 1 either reloads
//   N (auto_reload=1) or parks the block in DONE with count_out=0
//   (auto_reload=0). A load of zero is rejected with a one-cycle load_err.
//
//   Priority each cycle: clear > load > count_enable.
//   All outputs come straight from flops; none depends combinationally on
//   an input.
//
// Optional feature (macro COUNTDOWN_RELOAD_CNT_EN):
//   When defined, adds an 8-bit reload_cnt output counting auto-reload
//   terminal steps. It saturates at 255 and is cleared by rst, clear or a
//   valid load. When undefined, the port and its logic are absent.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   clear        in   synchronous return to IDLE
//   load         in   single-cycle load strobe
//   load_val     in   [NUM_CNT_BITS] start value captured on load
//   auto_reload  in   sampled on each terminal step: 1 reload, 0 stop
//   count_enable in   decrement strobe, honoured only in RUN
//   count_out    out  [NUM_CNT_BITS] current count
//   term_flag    out  high while count_out==1 in RUN
//   busy         out  high in RUN
//   done         out  high in DONE
//   reload_cnt   out  [8] auto-reload counter (macro builds only)
//   load_err     out  one-cycle pulse on a rejected (zero) load
// -----------------------------------------------------------------------------
module countdown_sequencer #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    auto_reload,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    term_flag,
  output logic                    busy,
  output logic                    done,
`ifdef COUNTDOWN_RELOAD_CNT_EN
  output logic [7:0]              reload_cnt,
`endif
  output logic                    load_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] CNT_TWO  = NUM_CNT_BITS'(2);

  state_t                  state_reg,    state_next;
  logic [NUM_CNT_BITS-1:0] count_reg,    count_next;
  logic [NUM_CNT_BITS-1:0] reload_reg,   reload_next;
  logic                    term_reg,     term_next;
  logic                    busy_reg,     busy_next;
  logic                    done_reg,     done_next;
  logic                    load_err_reg, load_err_next;

  // Terminal-step qualifier shared with the optional reload counter.
  logic                    reload_step;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= CNT_ZERO;
      reload_reg   <= CNT_ZERO;
      term_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      reload_reg   <= reload_next;
      term_reg     <= term_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    reload_next   = reload_reg;
    term_next     = term_reg;
    load_err_next = 1'b0;
    reload_step   = 1'b0;

    if (clear) begin
      state_next = ST_IDLE;
      count_next = CNT_ZERO;
      term_next  = 1'b0;
    end else if (load) begin
      if (load_val != CNT_ZERO) begin
        // Valid load restarts from any state, including mid-run.
        state_next  = ST_RUN;
        count_next  = load_val;
        reload_next = load_val;
        term_next   = (load_val == CNT_ONE);
      end else begin
        // Rejected load still wins priority, so a coincident enable is
        // dropped and everything else holds.
        load_err_next = 1'b1;
      end
    end else if (count_enable) begin
      case (state_reg)
        ST_RUN: begin
          if (count_reg > CNT_TWO) begin
            count_next = count_reg - CNT_ONE;
            term_next  = 1'b0;
          end else if (count_reg == CNT_TWO) begin
            count_next = CNT_ONE;
            term_next  = 1'b1;
          end else if (auto_reload) begin
            // Terminal step with reload: restart from the captured value.
            count_next  = reload_reg;
            term_next   = (reload_reg == CNT_ONE);
            reload_step = 1'b1;
          end else begin
            state_next = ST_DONE;
            count_next = CNT_ZERO;
            term_next  = 1'b0;
          end
        end
        default: begin
          // IDLE and DONE ignore count_enable.
        end
      endcase
    end

    // Status flags are registered copies of the next state.
    busy_next = (state_next == ST_RUN);
    done_next = (state_next == ST_DONE);
  end

  assign count_out = count_reg;
  assign term_flag = term_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign load_err  = load_err_reg;

`ifdef COUNTDOWN_RELOAD_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating count of auto-reload terminal steps
  // ---------------------------------------------------------------------------
  logic [7:0] reload_cnt_reg, reload_cnt_next;

  always_comb begin
    reload_cnt_next = reload_cnt_reg;
    if (clear || (load && (load_val != CNT_ZERO))) begin
      reload_cnt_next = 8'd0;
    end else if (reload_step && (reload_cnt_reg != 8'hFF)) begin
      reload_cnt_next = reload_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_cnt_reg <= 8'd0;
    end else begin
      reload_cnt_reg <= reload_cnt_next;
    end
  end

  assign reload_cnt = reload_cnt_reg;
`else
  // reload_step only feeds the optional counter.
  logic unused_reload_step;
  assign unused_reload_step = reload_step;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_countdown_sequencer
//
// Directed vectors for countdown_sequencer. Each vector drives the inputs for
// one clock and pushes the hand-computed expected outputs into a queue; a
// monitor pops one entry after every rising edge and compares it with the
// DUT outputs. The asynchronous mid-run reset is checked directly between
// edges.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         count_enable = 1'b0;
  logic [W-1:0] count_out;
  logic         term_flag;
  logic         busy;
  logic         done;
  logic         load_err;
  logic [7:0]   rc_obs;

  typedef struct {
    string        name;
    logic [W-1:0] cnt;
    logic         term;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   rc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  countdown_sequencer #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .auto_reload  (auto_reload),
    .count_enable (count_enable),
    .count_out    (count_out),
    .term_flag    (term_flag),
    .busy         (busy),
    .done         (done),
`ifdef COUNTDOWN_RELOAD_CNT_EN
    .reload_cnt   (rc_obs),
`endif
    .load_err     (load_err)
  );

`ifndef COUNTDOWN_RELOAD_CNT_EN
  assign rc_obs = 8'd0;
`endif

  always #5 clk = ~clk;

  // Compare one expected entry against the live outputs.
  task automatic compare(input exp_t e);
    logic ok;
    ok = (count_out === e.cnt) && (term_flag === e.term) && (busy === e.busy) &&
         (done === e.done) && (load_err === e.err);
`ifdef COUNTDOWN_RELOAD_CNT_EN
    ok = ok && (rc_obs === e.rc);
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d term=%0b busy=%0b done=%0b err=%0b rc=%0d, expected cnt=%0d term=%0b busy=%0b done=%0b err=%0b rc=%0d",
               e.name, count_out, term_flag, busy, done, load_err, rc_obs,
               e.cnt, e.term, e.busy, e.done, e.err, e.rc);
    end else begin
      $display("vec %0d %s: cnt=%0d term=%0b busy=%0b done=%0b err=%0b rc=%0d ok",
               n_vec, e.name, count_out, term_flag, busy, done, load_err, rc_obs);
    end
  endtask

  // Monitor: one pop per rising edge while entries are pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare(exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic vec(input string name,
                     input logic c, input logic l, input logic [W-1:0] lv,
                     input logic ar, input logic ce,
                     input logic [W-1:0] e_cnt, input logic e_term,
                     input logic e_busy, input logic e_done, input logic e_err,
                     input logic [7:0] e_rc);
    exp_t e;
    @(negedge clk);
    clear        = c;
    load         = l;
    load_val     = lv;
    auto_reload  = ar;
    count_enable = ce;
    e.name = name; e.cnt = e_cnt; e.term = e_term; e.busy = e_busy;
    e.done = e_done; e.err = e_err; e.rc = e_rc;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   waited;

    // Reset state, sampled while rst is still asserted.
    vec("reset",        0,0,8'd0,  0,0,  8'd0,0,0,0,0, 8'd0);
    @(posedge clk); #2 rst = 1'b0;
    vec("idle_ce",      0,0,8'd0,  0,1,  8'd0,0,0,0,0, 8'd0);

    // Asynchronous reset in the middle of a run.
    vec("mr_load5",     0,1,8'd5,  0,0,  8'd5,0,1,0,0, 8'd0);
    vec("mr_ce4",       0,0,8'd0,  0,1,  8'd4,0,1,0,0, 8'd0);
    vec("mr_ce3",       0,0,8'd0,  0,1,  8'd3,0,1,0,0, 8'd0);
    @(negedge clk);
    count_enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    e.name = "async_rst"; e.cnt = 8'd0; e.term = 0; e.busy = 0; e.done = 0; e.err = 0; e.rc = 8'd0;
    compare(e);
    @(negedge clk); rst = 1'b0;
    vec("post_rst_ce",  0,0,8'd0,  0,1,  8'd0,0,0,0,0, 8'd0);

    // Single shot from 4.
    vec("ss_load4",     0,1,8'd4,  0,0,  8'd4,0,1,0,0, 8'd0);
    vec("ss_ce3",       0,0,8'd0,  0,1,  8'd3,0,1,0,0, 8'd0);
    vec("ss_ce2",       0,0,8'd0,  0,1,  8'd2,0,1,0,0, 8'd0);
    vec("ss_ce1",       0,0,8'd0,  0,1,  8'd1,1,1,0,0, 8'd0);
    vec("ss_done",      0,0,8'd0,  0,1,  8'd0,0,0,1,0, 8'd0);
    vec("ss_done_ce",   0,0,8'd0,  0,1,  8'd0,0,0,1,0, 8'd0);
    vec("ss_done_ce2",  0,0,8'd0,  0,1,  8'd0,0,0,1,0, 8'd0);

    // Zero load in DONE is rejected; then a valid load restarts.
    vec("done_load0",   0,1,8'd0,  0,0,  8'd0,0,0,1,1, 8'd0);
    vec("done_err_off", 0,0,8'd0,  0,0,  8'd0,0,0,1,0, 8'd0);
    vec("done_load2",   0,1,8'd2,  0,0,  8'd2,0,1,0,0, 8'd0);
    vec("run_hold",     0,0,8'd0,  0,0,  8'd2,0,1,0,0, 8'd0);

    // Auto-reload from 3.
    vec("ar_load3",     0,1,8'd3,  1,0,  8'd3,0,1,0,0, 8'd0);
    vec("ar_ce2",       0,0,8'd0,  1,1,  8'd2,0,1,0,0, 8'd0);
    vec("ar_ce1",       0,0,8'd0,  1,1,  8'd1,1,1,0,0, 8'd0);
    vec("ar_reload3",   0,0,8'd0,  1,1,  8'd3,0,1,0,0, 8'd1);
    vec("ar_ce2b",      0,0,8'd0,  1,1,  8'd2,0,1,0,0, 8'd1);
    vec("ar_ce1b",      0,0,8'd0,  1,1,  8'd1,1,1,0,0, 8'd1);
    vec("ar_reload3b",  0,0,8'd0,  1,1,  8'd3,0,1,0,0, 8'd2);
    vec("ar_hold",      0,0,8'd0,  1,0,  8'd3,0,1,0,0, 8'd2);

    // Load of 1.
    vec("one_load",     0,1,8'd1,  0,0,  8'd1,1,1,0,0, 8'd0);
    vec("one_stop",     0,0,8'd0,  0,1,  8'd0,0,0,1,0, 8'd0);
    vec("one_load_ar",  0,1,8'd1,  1,0,  8'd1,1,1,0,0, 8'd0);
    vec("one_reload",   0,0,8'd0,  1,1,  8'd1,1,1,0,0, 8'd1);
    vec("one_reload2",  0,0,8'd0,  1,1,  8'd1,1,1,0,0, 8'd2);
    // Zero load mid-run beats a coincident enable.
    vec("run_load0_ce", 0,1,8'd0,  1,1,  8'd1,1,1,0,1, 8'd2);

    // Priority cases.
    vec("pr_load3",     0,1,8'd3,  0,0,  8'd3,0,1,0,0, 8'd0);
    vec("pr_ce2",       0,0,8'd0,  0,1,  8'd2,0,1,0,0, 8'd0);
    vec("pr_load9_ce",  0,1,8'd9,  0,1,  8'd9,0,1,0,0, 8'd0);
    vec("pr_clr_load",  1,1,8'd5,  0,0,  8'd0,0,0,0,0, 8'd0);
    vec("pr_idle_ce",   0,0,8'd0,  0,1,  8'd0,0,0,0,0, 8'd0);
    vec("pr_load1",     0,1,8'd1,  0,0,  8'd1,1,1,0,0, 8'd0);
    vec("pr_done",      0,0,8'd0,  0,1,  8'd0,0,0,1,0, 8'd0);
    vec("pr_clr_done",  1,0,8'd0,  0,0,  8'd0,0,0,0,0, 8'd0);

    // Maximum load: 254 enables reach 1, then reload to 255.
    vec("max_load",     0,1,8'd255,0,0,  8'd255,0,1,0,0, 8'd0);
    for (int i = 1; i <= 254; i++) begin
      vec("max_ce",     0,0,8'd0,  0,1,  8'(255 - i), (i == 254), 1,0,0, 8'd0);
    end
    vec("max_reload",   0,0,8'd0,  1,1,  8'd255,0,1,0,0, 8'd1);
    vec("max_clear",    1,0,8'd0,  1,1,  8'd0,0,0,0,0, 8'd0);

    @(negedge clk);
    clear = 0; load = 0; count_enable = 0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
